// File: rtl/fetch_unit.sv
// fetch_unit: program counter, instruction fetch with valid/ready hand-off to decode,
// execute-stage redirects and an optional CALL/RET return-address stack (FETCH_RAS_EN).
module fetch_unit #(
    parameter int PC_W      = 10,
    parameter int INSTR_W   = 9,
    parameter int RAS_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [PC_W-1:0]    start_addr,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [1:0]         redirect_kind,
    input  logic [PC_W-1:0]    redirect_target,
    input  logic [PC_W-1:0]    redirect_link,
    output logic               halted,
    output logic               ras_err
);

    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] redirect_pc;
    logic            advance;
    logic            is_halt;

    assign imem_addr = pc;
    assign advance   = !instr_valid || instr_ready;
    // HALT is opcode 5'b1111x, so only the top four instruction bits matter.
    assign is_halt   = (imem_data[INSTR_W-1 -: 4] == 4'hF);

`ifdef FETCH_RAS_EN
    typedef enum logic [1:0] {
        KIND_JUMP = 2'b00,
        KIND_CALL = 2'b01,
        KIND_RET  = 2'b10,
        KIND_RSVD = 2'b11
    } kind_t;

    localparam int            SP_W     = $clog2(RAS_DEPTH);
    localparam logic [SP_W:0] RAS_FULL = (SP_W+1)'(RAS_DEPTH);

    logic [PC_W-1:0] ras_mem [RAS_DEPTH];
    logic [SP_W-1:0] sp;
    logic [SP_W:0]   count;
    kind_t           kind;
    logic            take_redirect;
    logic            do_push;
    logic            do_pop;
    logic            ras_empty;

    assign kind          = kind_t'(redirect_kind);
    assign take_redirect = redirect && (state != IDLE);
    assign do_push       = take_redirect && (kind == KIND_CALL);
    assign do_pop        = take_redirect && (kind == KIND_RET);
    assign ras_empty     = (count == '0);

    always_comb begin
        // NOTE: default assigned first so every path drives redirect_pc and no latch is inferred.
        redirect_pc = redirect_target;
        if (do_pop) begin
            redirect_pc = ras_empty ? '0 : ras_mem[sp - 1'b1];
        end
    end

    // NOTE: the stack storage is not reset; count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            ras_mem[sp] <= redirect_link;
        end
    end

    // sp points at the next free slot; a push when full lands on the oldest entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            sp      <= '0;
            count   <= '0;
            ras_err <= 1'b0;
        end else if (do_push) begin
            sp <= sp + 1'b1;
            if (count == RAS_FULL) begin
                ras_err <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end else if (do_pop) begin
            if (ras_empty) begin
                ras_err <= 1'b1;
            end else begin
                sp    <= sp - 1'b1;
                count <= count - 1'b1;
            end
        end
    end
`else
    logic unused_ras_inputs;

    assign unused_ras_inputs = ^{redirect_kind, redirect_link};
    assign redirect_pc       = redirect_target;
    assign ras_err           = 1'b0;
`endif

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register updates from pre-edge values.
        if (reset) begin
            state       <= IDLE;
            pc          <= '0;
            instr_out   <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pc    <= start_addr;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (redirect) begin
                        instr_valid <= 1'b0;
                        pc          <= redirect_pc;
                        state       <= RUN;
                        halted      <= 1'b0;
                    end else if (advance) begin
                        instr_out   <= imem_data;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        if (is_halt) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end else begin
                            pc <= pc + 1'b1;
                        end
                    end
                end
                HALTED: begin
                    if (redirect) begin
                        instr_valid <= 1'b0;
                        pc          <= redirect_pc;
                        state       <= RUN;
                        halted      <= 1'b0;
                    end else begin
                        // The HALT instruction stays offered until decode takes it.
                        if (instr_valid && instr_ready) begin
                            instr_valid <= 1'b0;
                        end
                        if (start) begin
                            pc     <= start_addr;
                            state  <= RUN;
                            halted <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
